// File: rtl/riscv_selftest_ctrl.sv
// Power-on / bench self-check sequencer for the single-cycle RISC-V core: reset, run, read back and compare registers.
// Optional SELFTEST_CAPTURE_EN adds fail_reg/fail_actual capture of the first mismatching register.
module riscv_selftest_ctrl #(
  parameter int unsigned XLEN         = 32,
  parameter int unsigned REG_AW       = 5,
  parameter int unsigned NUM_CHECKS   = 8,
  parameter int unsigned RESET_CYCLES = 2,
  parameter int unsigned RUN_CYCLES   = 25,
  localparam int unsigned IDX_W = (NUM_CHECKS > 1) ? $clog2(NUM_CHECKS) : 1,
  localparam int unsigned FC_W  = $clog2(NUM_CHECKS + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic [IDX_W-1:0]  cfg_idx,
  input  logic              cfg_valid,
  input  logic [REG_AW-1:0] cfg_reg,
  input  logic [XLEN-1:0]   cfg_exp,
  input  logic              start,
  output logic              dut_rst,
  output logic              dbg_ren,
  output logic [REG_AW-1:0] dbg_raddr,
  input  logic [XLEN-1:0]   dbg_rdata,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [FC_W-1:0]   fail_count,
  output logic [IDX_W-1:0]  first_fail_idx
`ifdef SELFTEST_CAPTURE_EN
  ,
  output logic [REG_AW-1:0] fail_reg,
  output logic [XLEN-1:0]   fail_actual
`endif
);

  localparam int unsigned MAX_HR  = (RESET_CYCLES > RUN_CYCLES) ? RESET_CYCLES : RUN_CYCLES;
  localparam int unsigned MAX_CNT = (MAX_HR > NUM_CHECKS + 1) ? MAX_HR : NUM_CHECKS + 1;
  localparam int unsigned CNT_W   = $clog2(MAX_CNT + 1);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_HOLD  = 3'd1;
  localparam logic [2:0] ST_RUN   = 3'd2;
  localparam logic [2:0] ST_CHECK = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic              tbl_valid [NUM_CHECKS];
  logic [REG_AW-1:0] tbl_reg   [NUM_CHECKS];
  logic [XLEN-1:0]   tbl_exp   [NUM_CHECKS];

  logic [IDX_W-1:0] ren_idx_q;
  logic             cmp_valid_q;
  logic [IDX_W-1:0] cmp_idx_q;

  logic             accept_c;
  logic             chk_live_c;
  logic [IDX_W-1:0] chk_idx_c;
  logic             mismatch_c;
  logic [FC_W-1:0]  fc_d;
  logic [IDX_W-1:0] ffi_d;

  // A restart from DONE waits for done to be visible so the last compare has drained.
  assign accept_c   = start && ((state_q == ST_IDLE) || ((state_q == ST_DONE) && done));
  assign chk_live_c = (state_q == ST_CHECK) && (cnt_q < CNT_W'(NUM_CHECKS));
  assign chk_idx_c  = chk_live_c ? IDX_W'(cnt_q) : '0;
  assign mismatch_c = cmp_valid_q && (dbg_rdata != tbl_exp[cmp_idx_q]);

  always_comb begin
    fc_d  = fail_count;
    ffi_d = first_fail_idx;
    if (accept_c) begin
      fc_d  = '0;
      ffi_d = '0;
    end else if (mismatch_c) begin
      fc_d = fail_count + FC_W'(1);
      if (fail_count == '0) ffi_d = cmp_idx_q;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic; CHECK spends one extra cycle so the compare pipeline can drain.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (accept_c) begin
          state_d = ST_HOLD;
          cnt_d   = '0;
        end
      end
      ST_HOLD: begin
        if (cnt_q == CNT_W'(RESET_CYCLES - 1)) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_RUN: begin
        if (cnt_q == CNT_W'(RUN_CYCLES - 1)) begin
          state_d = ST_CHECK;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_CHECK: begin
        if (cnt_q == CNT_W'(NUM_CHECKS)) begin
          state_d = ST_DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Check table; only writable while idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(NUM_CHECKS); i++) begin
        tbl_valid[i] <= 1'b0;
        tbl_reg[i]   <= '0;
        tbl_exp[i]   <= '0;
      end
    end else if (cfg_we && (state_q == ST_IDLE)) begin
      tbl_valid[cfg_idx] <= cfg_valid;
      tbl_reg[cfg_idx]   <= cfg_reg;
      tbl_exp[cfg_idx]   <= cfg_exp;
    end
  end

  // Registered outputs follow the state one cycle later; read/compare pipeline rides alongside.
  always_ff @(posedge clk) begin
    if (rst) begin
      dut_rst        <= 1'b1;
      dbg_ren        <= 1'b0;
      dbg_raddr      <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      fail_count     <= '0;
      first_fail_idx <= '0;
      ren_idx_q      <= '0;
      cmp_valid_q    <= 1'b0;
      cmp_idx_q      <= '0;
    end else begin
      dut_rst <= (state_q == ST_IDLE) || (state_q == ST_HOLD);
      dbg_ren <= chk_live_c && tbl_valid[chk_idx_c];
      if (chk_live_c) dbg_raddr <= tbl_reg[chk_idx_c];
      ren_idx_q      <= chk_idx_c;
      cmp_valid_q    <= dbg_ren;
      cmp_idx_q      <= ren_idx_q;
      busy           <= accept_c || (state_q inside {ST_HOLD, ST_RUN, ST_CHECK});
      done           <= (state_q == ST_DONE) && !accept_c;
      pass           <= (state_q == ST_DONE) && !accept_c && (fc_d == '0);
      fail_count     <= fc_d;
      first_fail_idx <= ffi_d;
    end
  end

`ifdef SELFTEST_CAPTURE_EN
  // First-mismatch capture of register number and observed data.
  always_ff @(posedge clk) begin
    if (rst || accept_c) begin
      fail_reg    <= '0;
      fail_actual <= '0;
    end else if (mismatch_c && (fail_count == '0)) begin
      fail_reg    <= tbl_reg[cmp_idx_q];
      fail_actual <= dbg_rdata;
    end
  end
`endif

endmodule

// File: doc/riscv_selftest_ctrl.md
# riscv_selftest_ctrl

Synthesizable self-check controller for the single-cycle RISC-V core. It sequences a directed program run by holding the core in reset, releasing it for a programmed number of cycles, and reading back a table of architectural registers through the register file's debug read port. It compares each register against an expected value and reports pass/fail with mismatch details. It replaces hand-timed register checks in benches and serves as an on-board power-on self test; it sits beside `risc_processor` and drives that block's reset.

## Interface
- `XLEN`, 32: data width of registers and expected values.
- `REG_AW`, 5: register address width.
- `NUM_CHECKS`, 8: check-table depth (≥1).
- `RESET_CYCLES`, 2: cycles `dut_rst` is held after start (≥1).
- `RUN_CYCLES`, 25: cycles the core runs before checking (≥1).
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `cfg_we` in 1: check-table write strobe; honoured only in IDLE.
- `cfg_idx` in clog2(NUM_CHECKS): table entry index.
- `cfg_valid` in 1: entry enable bit.
- `cfg_reg` in REG_AW: register to check.
- `cfg_exp` in XLEN: expected value.
- `start` in 1: one-cycle pulse; honoured only in IDLE or DONE.
- `dut_rst` out 1: reset to the core.
- `dbg_ren` out 1: debug read strobe.
- `dbg_raddr` out REG_AW: debug read address.
- `dbg_rdata` in XLEN: debug read data; registered, valid one cycle after `dbg_ren`.
- `busy` out 1: high from start acceptance until DONE.
- `done` out 1: high in DONE.
- `pass` out 1: valid while `done`; 1 iff no enabled entry mismatched.
- `fail_count` out clog2(NUM_CHECKS+1): number of mismatching entries.
- `first_fail_idx` out clog2(NUM_CHECKS): index of the first mismatch; 0 if none.

## Operation
- FSM states: IDLE, HOLD, RUN, CHECK, DONE.
- IDLE: `dut_rst`=1, table writable. `start` clears `fail_count`, `first_fail_idx`, and the capture registers, then enters HOLD.
- HOLD: `dut_rst`=1 for RESET_CYCLES cycles, then enter RUN.
- RUN: `dut_rst`=0 for RUN_CYCLES cycles, then enter CHECK.
- CHECK: walks index 0..NUM_CHECKS-1, one index per cycle. An enabled entry drives `dbg_ren`=1 with `dbg_raddr`=`cfg_reg`. A disabled entry drives `dbg_ren`=0 and is skipped without compare.
- Compare: the compare stage is registered. Data returned for entry i is compared in the following cycle. On inequality, `fail_count` increments; on the first mismatch only, `first_fail_idx` is set to i.
- Exit from CHECK: after the last compare completes, enter DONE. CHECK lasts NUM_CHECKS+1 cycles.
- DONE: `dut_rst`=0, so the core keeps running; test programs end in a self-loop. `pass`=(`fail_count`==0). `start` re-runs the test and re-enters HOLD.
- Table contents: preserved across runs. Cleared (all `cfg_valid`=0) only by `rst`.
- All enables clear: the run passes with `fail_count`=0.
- `start` and `cfg_we` in the same IDLE cycle: the write lands first and is used by the run.
- `rst` mid-operation: returns to IDLE next edge, `dut_rst`=1, all status cleared. Any compare still in flight is discarded.

## Timing
- Reset values: `dut_rst`=1, `dbg_ren`=0, `dbg_raddr`=0, `busy`=0, `done`=0, `pass`=0, `fail_count`=0, `first_fail_idx`=0.
- `start` accepted at edge T: `dut_rst`=1 for T+1..T+RESET_CYCLES; low from T+RESET_CYCLES+1.
- First `dbg_ren` at T+RESET_CYCLES+RUN_CYCLES+1.
- `done` rises at T+RESET_CYCLES+RUN_CYCLES+NUM_CHECKS+2. `busy` falls the same cycle.
- `pass`, `fail_count`, `first_fail_idx` are stable from the cycle `done` rises until the next `start` or `rst`.
- `start` while `busy`: ignored. `cfg_we` while not IDLE: ignored.

## Configuration
- `SELFTEST_CAPTURE_EN` defined: adds ports `fail_reg` (REG_AW) and `fail_actual` (XLEN). At the first mismatch they latch the checked register and the observed `dbg_rdata`. They reset and clear to 0 on `start`.
- Undefined: these ports and registers do not exist; all other behaviour is identical.

## Test plan
- Nominal: x1=5, x2=3 preloaded, data mem[0]=0x0A. Table: x3=8, x4=2, x5=6, x6=0x0A, x7=5. `start` → `done` at T+2+25+8+2, `pass`=1, `fail_count`=0.
- Single mismatch: entry 2 expects x5=0x7 → `pass`=0, `fail_count`=1, `first_fail_idx`=2. With the macro, `fail_reg`=5 and `fail_actual`=6.
- Multiple mismatches plus a disabled entry: entries 1 and 4 wrong, entry 3 disabled → `fail_count`=2, `first_fail_idx`=1, and no `dbg_ren` issued for index 3.
- Timing check: count cycles from `start` → `dut_rst` is high for exactly 2 cycles and low for 25 cycles before the first `dbg_ren`. `start` pulsed during RUN → ignored.
- Reset mid-CHECK: assert `rst` on the 3rd CHECK cycle → next cycle IDLE, `dut_rst`=1, `fail_count`=0, all table entries disabled.
- Re-run from DONE: change entry 0 in IDLE after `rst`, rerun twice without `rst` → results are identical and the table is preserved between runs.
